// File: rtl/sevsegfx_pkg.sv
// ---------------------------------------------------------------------------
// sevsegfx_pkg
// Shared definitions for the seven-segment effects blocks: step-mode
// encoding, bounce direction, LFSR tap mask, default seed and a helper
// that maps an all-zero seed (a lock-up state) to a usable one.
// ---------------------------------------------------------------------------
package sevsegfx_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_COUNT  = 2'b01,
    MODE_RANDOM = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Feedback taps b7, b5, b4, b3 of the 8-bit Fibonacci LFSR.
  localparam logic [7:0] LFSR_TAPS    = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'hA5;

  // An all-zero LFSR never leaves zero, so that seed is replaced by 1.
  function automatic logic [7:0] lfsr_start(input logic [7:0] seed);
    return (seed == 8'h00) ? 8'h01 : seed;
  endfunction

endpackage

// File: rtl/seq_lfsr8.sv
// ---------------------------------------------------------------------------
// seq_lfsr8
// Free-running 8-bit Fibonacci LFSR. Shifts left every clock; the new LSB
// is the XOR of the tapped bits. A zero seed is substituted with 8'h01.
//
// Ports:
//   clk   in   1  clock
//   rst   in   1  asynchronous active-high reset (loads the seed)
//   state out  8  full LFSR state
// ---------------------------------------------------------------------------
module seq_lfsr8
  import sevsegfx_pkg::*;
#(
  parameter logic [7:0] SEED = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] state
);

  localparam logic [7:0] START = lfsr_start(SEED);

  logic feedback;
  assign feedback = ^(state & LFSR_TAPS);

  // NOTE: sequential state is always written with non-blocking (<=) so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= START;
    end else begin
      state <= {state[6:0], feedback};
    end
  end

endmodule

// File: rtl/pattern_sequencer.sv
// ---------------------------------------------------------------------------
// pattern_sequencer
// Produces the 3-bit pattern index for the downstream seven-segment
// pattern decoder. A programmable prescaler paces automatic advances; a
// synchronized, edge-detected manual step input also advances. Modes: hold,
// count-up, random (LFSR, never repeats the current value) and bounce.
//
// Build option: define SEQ_REVERSE_EN to add i_reverse, which makes count
// mode decrement (0 -> 7) instead of increment.
//
// Ports:
//   i_clk     in   1          system clock
//   i_rst     in   1          asynchronous active-high reset
//   i_div     in   DIV_WIDTH  step period = i_div+1 clocks
//   i_mode    in   2          00 hold, 01 count, 10 random, 11 bounce
//   i_run     in   1          enables prescaler-driven auto advance
//   i_step    in   1          asynchronous manual step, rising edge advances
//   i_reverse in   1          (SEQ_REVERSE_EN only) count mode decrements
//   o_count   out  3          pattern index
//   o_tick    out  1          high the cycle o_count shows a new value
// ---------------------------------------------------------------------------
module pattern_sequencer
  import sevsegfx_pkg::*;
#(
  parameter int         DIV_WIDTH = 12,
  parameter logic [7:0] LFSR_SEED = DEFAULT_SEED
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DIV_WIDTH-1:0] i_div,
  input  logic [1:0]           i_mode,
  input  logic                 i_run,
  input  logic                 i_step,
`ifdef SEQ_REVERSE_EN
  input  logic                 i_reverse,
`endif
  output logic [2:0]           o_count,
  output logic                 o_tick
);

  mode_e mode;
  assign mode = mode_e'(i_mode);

  // -------------------------------------------------------------------------
  // Prescaler. The >= compare makes a lowered i_div take effect at once:
  // a count already past the new limit wraps on the next clock.
  // -------------------------------------------------------------------------
  logic [DIV_WIDTH-1:0] presc;
  logic                 presc_en;
  logic                 presc_wrap;
  logic                 auto_adv;

  assign presc_en   = i_run && (mode != MODE_HOLD);
  assign presc_wrap = (presc >= i_div);
  assign auto_adv   = presc_en && presc_wrap;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      presc <= '0;
    end else if (!presc_en || presc_wrap) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Manual step: two-flop synchronizer, then a delay flop for edge detect.
  // A held-high input yields a single edge.
  // -------------------------------------------------------------------------
  logic step_sync1;
  logic step_sync2;
  logic step_dly;
  logic step_edge;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      step_sync1 <= 1'b0;
      step_sync2 <= 1'b0;
      step_dly   <= 1'b0;
    end else begin
      step_sync1 <= i_step;
      step_sync2 <= step_sync1;
      step_dly   <= step_sync2;
    end
  end

  assign step_edge = step_sync2 & ~step_dly;

  // Coincident auto and manual events merge into one advance; hold mode
  // ignores manual steps.
  logic advance;
  assign advance = (auto_adv | step_edge) && (mode != MODE_HOLD);

  // -------------------------------------------------------------------------
  // Random source. Only the low three bits feed the candidate value.
  // -------------------------------------------------------------------------
  logic [7:0] lfsr;
  logic       lfsr_unused;

  seq_lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (i_clk),
    .rst   (i_rst),
    .state (lfsr)
  );

  assign lfsr_unused = ^lfsr[7:3];

  // -------------------------------------------------------------------------
  // Sequencer: state register plus next-value logic. Bounce direction
  // survives mode changes; o_count is only ever changed by an advance.
  // -------------------------------------------------------------------------
  dir_e       dir;
  dir_e       next_dir;
  logic [2:0] next_count;
  logic [2:0] cand;
  logic       count_down;

`ifdef SEQ_REVERSE_EN
  assign count_down = i_reverse;
`else
  assign count_down = 1'b0;
`endif

  assign cand = lfsr[2:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_count <= 3'd0;
      o_tick  <= 1'b0;
      dir     <= DIR_UP;
    end else begin
      o_tick <= advance;
      if (advance) begin
        o_count <= next_count;
        dir     <= next_dir;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    next_count = o_count;
    next_dir   = dir;
    unique case (mode)
      MODE_COUNT: begin
        next_count = count_down ? (o_count - 3'd1) : (o_count + 3'd1);
      end
      MODE_RANDOM: begin
        // Bump a candidate that equals the current index so the display
        // never appears to stall.
        next_count = (cand == o_count) ? (cand + 3'd1) : cand;
      end
      MODE_BOUNCE: begin
        if (dir == DIR_UP) begin
          if (o_count == 3'd7) begin
            next_count = 3'd6;
            next_dir   = DIR_DOWN;
          end else begin
            next_count = o_count + 3'd1;
          end
        end else begin
          if (o_count == 3'd0) begin
            next_count = 3'd1;
            next_dir   = DIR_UP;
          end else begin
            next_count = o_count - 3'd1;
          end
        end
      end
      default: begin
        next_count = o_count;
      end
    endcase
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pattern_sequencer
// Self-checking bench for pattern_sequencer. A behavioural model predicts
// each advance and queues the expected index; a monitor compares whenever
// the DUT raises o_tick, and also tracks o_count between ticks.
// ---------------------------------------------------------------------------
module tb_pattern_sequencer;
  import sevsegfx_pkg::*;

  localparam int DIV_WIDTH = 12;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [DIV_WIDTH-1:0] div;
  logic [1:0]           mode;
  logic                 run;
  logic                 step;
  logic [2:0]           count;
  logic                 tick;
`ifdef SEQ_REVERSE_EN
  logic                 reverse = 1'b0;
`endif

  pattern_sequencer #(
    .DIV_WIDTH (DIV_WIDTH),
    .LFSR_SEED (8'hA5)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_div     (div),
    .i_mode    (mode),
    .i_run     (run),
    .i_step    (step),
`ifdef SEQ_REVERSE_EN
    .i_reverse (reverse),
`endif
    .o_count   (count),
    .o_tick    (tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: evaluated at each rising edge from the inputs the
  // bench is driving, using the rules of the sequencer directly.
  // ---------------------------------------------------------------------
  typedef struct {
    int cyc;
    int val;
  } exp_t;

  exp_t       sb[$];
  int         cyc;
  int         m_presc;
  int         m_count;
  bit         m_up;
  logic [7:0] m_lfsr;
  bit         h1, h2, h3;   // i_step as sampled 1, 2 and 3 edges ago
  bit         m_en, m_auto, m_stepadv, m_adv;
  int         m_cand, m_next;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc     = 0;
      m_presc = 0;
      m_count = 0;
      m_up    = 1'b1;
      m_lfsr  = 8'hA5;
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      sb.delete();
    end else begin
      cyc++;
      m_en      = run && (mode != MODE_HOLD);
      m_auto    = m_en && (m_presc >= int'(div));
      m_stepadv = h2 && !h3;
      m_adv     = (m_auto || m_stepadv) && (mode != MODE_HOLD);
      if (m_adv) begin
        m_next = m_count;
        case (mode)
          MODE_COUNT:  m_next = (m_count + 1) % 8;
          MODE_RANDOM: begin
            m_cand = int'(m_lfsr) % 8;
            m_next = (m_cand == m_count) ? (m_cand + 1) % 8 : m_cand;
          end
          MODE_BOUNCE: begin
            if (m_up) begin
              if (m_count == 7) begin m_next = 6; m_up = 1'b0; end
              else m_next = m_count + 1;
            end else begin
              if (m_count == 0) begin m_next = 1; m_up = 1'b1; end
              else m_next = m_count - 1;
            end
          end
          default: m_next = m_count;
        endcase
        m_count = m_next;
        sb.push_back('{cyc, m_next});
      end
      m_presc = (!m_en || m_auto) ? 0 : m_presc + 1;
      m_lfsr  = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      h3 = h2; h2 = h1; h1 = step;
    end
  end

  // ---------------------------------------------------------------------
  // Monitor: samples on the falling edge.
  // ---------------------------------------------------------------------
  bit   rand_phase = 1'b0;
  bit   have_prev;
  int   prev_val;
  int   repeats;
  bit   seen [8];
  exp_t e;

  always @(negedge clk) begin
    if (!rst) begin
      if (tick) begin
        if (sb.size() == 0) begin
          check("unexpected_tick", tick, 1'b0);
        end else begin
          e = sb.pop_front();
          check("tick_cycle", cyc, e.cyc);
          check("tick_count", count, e.val);
        end
        if (rand_phase) begin
          if (have_prev && int'(count) == prev_val) repeats++;
          prev_val  = int'(count);
          have_prev = 1'b1;
          seen[count] = 1'b1;
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        check("missed_tick", tick, 1'b1);
      end
      check("count_track", count, m_count);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  int bounce_exp [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
  int k;
  int c0;
  int nseen;

  initial begin
    rst = 1'b1; div = '0; mode = MODE_HOLD; run = 1'b0; step = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_count", count, 0);
    check("reset_tick", tick, 0);

    // 1: run to 5, async reset mid-run, then div=3 pacing.
    rst = 1'b0; mode = MODE_COUNT; run = 1'b1; div = 0;
    repeat (5) @(negedge clk);
    check("pre_reset_count", count, 5);
    #2 rst = 1'b1;
    #1;
    check("async_reset_count", count, 0);
    check("async_reset_tick", tick, 0);
    @(negedge clk);
    rst = 1'b0; div = 3;
    k = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      check("div3_tick_phase", tick, (i % 4) == 0);
      if (tick) k++;
    end
    check("div3_tick_total", k, 8);
    check("div3_wrap_count", count, 0);

    // 2: div=0 advances every clock.
    div = 0;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tick) k++;
    end
    check("div0_ticks", k, 8);
    check("div0_wrap_count", count, 0);

    // 3: bounce from 0.
    mode = MODE_BOUNCE;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("bounce_seq", count, bounce_exp[i]);
    end

    // 4: random mode from the reset seed, 512 advances.
    rst = 1'b1;
    @(negedge clk);
    have_prev = 1'b0; repeats = 0;
    for (int i = 0; i < 8; i++) seen[i] = 1'b0;
    rst = 1'b0; mode = MODE_RANDOM; run = 1'b1; div = 0; rand_phase = 1'b1;
    repeat (512) @(negedge clk);
    #1 rand_phase = 1'b0;
    nseen = 0;
    for (int i = 0; i < 8; i++) if (seen[i]) nseen++;
    check("random_repeats", repeats, 0);
    check("random_all_values", nseen, 8);

    // 5: manual step while paused, held high for five clocks.
    @(negedge clk);
    run = 1'b0; mode = MODE_COUNT;
    repeat (4) @(negedge clk);
    c0 = m_count;
    step = 1'b1;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check("step_tick_timing", tick, i == 3);
      if (tick) k++;
      if (i == 5) step = 1'b0;
    end
    check("step_single_tick", k, 1);
    check("step_count", count, (c0 + 1) % 8);

    mode = MODE_HOLD;
    c0 = m_count;
    step = 1'b1;
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (tick) k++;
      if (i == 5) step = 1'b0;
    end
    check("hold_step_ticks", k, 0);
    check("hold_step_count", count, c0);

    // 6: lowering div below the prescaler, then step coinciding with a wrap.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mode = MODE_COUNT; run = 1'b1; div = 10;
    repeat (8) @(negedge clk);
    div = 2;
    @(negedge clk);
    check("div_lower_tick", tick, 1);
    check("div_lower_count", count, 1);
    div = 3;
    @(negedge clk);
    check("coinc_pre_tick", tick, 0);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("coinc_pre_tick", tick, 0);
    @(negedge clk);
    check("coinc_pre_tick", tick, 0);
    @(negedge clk);
    check("coinc_tick", tick, 1);
    check("coinc_single_inc", count, 2);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) div  = DIV_WIDTH'($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) run  = ~run;
      if ($urandom_range(0, 3) == 0) step = ~step;
    end
    step = 1'b0; run = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
